character_buffer_writer: RTL and testbench
==========================================

// Module: character_buffer_writer
// PURPOSE
// - Upstream stage of character_buffer_registerfile: accepts decoded ASCII bytes from the keyboard decoder and packs them 8 per 64-bit word.
// - Writes the updated word into registerfile entries 1..31 (entry 0 is hardwired zero) after every accepted byte; supports backspace and bulk clear.
// - Uses registerfile read port B to refetch the previous word when a backspace crosses a word boundary.
// PARAMETERS
// - WORD_BYTES      8      bytes per registerfile word; byte 0 = data[7:0] is the first character
// - FIRST_ADDR      5'd1   first writable registerfile entry
// - LAST_ADDR       5'd31  last writable registerfile entry
// - BACKSPACE_CODE  8'h08  input code treated as backspace; never stored
// PORTS
// - clock        in   1   single clock; all state updates on rising edge
// - reset        in   1   asynchronous, active-low reset
// - char_in      in   8   ASCII code from the keyboard decoder
// - char_valid   in   1   char_in valid; a byte transfers when char_valid && char_ready
// - char_ready   out  1   block can accept a byte (high only in IDLE)
// - clear        in   1   request to zero the whole buffer; sampled only in IDLE
// - data_out     out  64  write data to registerfile data_in
// - address      out  5   write address to registerfile address
// - write        out  1   registerfile write strobe, one cycle per write
// - select_b     out  5   registerfile read select B (used during FETCH)
// - rf_out_b     in   64  registerfile out_b (combinational read)
// - cursor_addr  out  5   entry of the next byte slot
// - cursor_byte  out  3   byte lane of the next byte slot
// - full         out  1   all 31*8 slots written
// - overflow     out  1   one-cycle pulse: byte dropped because full
// BEHAVIOUR
// - Reset: state IDLE, word=0, cursor_addr=FIRST_ADDR, cursor_byte=0, full=0, overflow=0, write=0, data_out=0, address=FIRST_ADDR, select_b=0.
// - States: IDLE, WRITE, FETCH, CLEAR. Only IDLE asserts char_ready.
// - IDLE, priority clear > char_valid:
//   - clear: go CLEAR with sweep address = FIRST_ADDR.
//   - byte != BACKSPACE_CODE and !full: word[cursor_byte] <= byte; advance flag = 1; go WRITE.
//   - byte != BACKSPACE_CODE and full: byte dropped; overflow=1 for one cycle; stay IDLE.
//   - backspace, full: word[7] <= 0; full <= 0; cursor stays (31,7); advance flag = 0; go WRITE.
//   - backspace, cursor_byte > 0: cursor_byte--; that lane <= 0; advance flag = 0; go WRITE.
//   - backspace, cursor_byte == 0 and cursor_addr > FIRST_ADDR: go FETCH.
//   - backspace at (FIRST_ADDR,0): ignored, no write, stay IDLE.
// - WRITE (1 cycle): write=1, address=cursor_addr, data_out=word. If advance flag set:
//   - cursor_byte < 7: cursor_byte++.
//   - cursor_byte == 7 and cursor_addr < LAST_ADDR: cursor_addr++, cursor_byte=0, word=0.
//   - cursor_byte == 7 and cursor_addr == LAST_ADDR: full <= 1, cursor holds.
//   - Always return to IDLE.
// - FETCH (1 cycle): select_b = cursor_addr-1; word <= rf_out_b with lane 7 forced 0; cursor_addr--; cursor_byte=7; advance flag = 0; go WRITE.
// - CLEAR: write=1, data_out=0, address = sweep address; sweep FIRST_ADDR..LAST_ADDR (31 cycles). On last: word=0, cursor=(FIRST_ADDR,0), full=0; go IDLE. char_valid is ignored throughout.
// - write is low in IDLE and FETCH; data_out and address hold their last values when write is low.
// - Latency: accepted byte to write pulse is 1 cycle; boundary backspace is 2 cycles; worst case back-to-back throughput is 1 byte per 2 cycles.
// - Asserting reset mid-CLEAR or mid-WRITE aborts immediately to reset values; registerfile contents are not restored.
// STRUCTURE
// - Shared package (keyboard_pkg):
//   - state encoding: IDLE/WRITE/FETCH/CLEAR
//   - BACKSPACE_CODE, FIRST_ADDR, LAST_ADDR
// - Sub-module byte_lane_update: combinational; 64-bit word + 3-bit lane + 8-bit value -> word with that lane replaced.
// - Used for both insert (value = char) and erase (value = 0).
// TESTING (bench models registerfile as a 32x64 array, entry 0 reads 0)
// - Reset, type "AB":
//   - write pulses at addr 1 with data 64'h41 then 64'h4241.
//   - cursor ends at (1,2).
// - Type 8 bytes 0x30..0x37:
//   - 8th write is addr 1 data 64'h3736353433323130.
//   - cursor ends at (2,0); next byte writes addr 2 lane 0.
// - Cursor at (2,0), send 0x08:
//   - FETCH drives select_b=1.
//   - WRITE addr 1 data 64'h0036353433323130; cursor (1,7).
// - Fill all 248 slots:
//   - full=1.
//   - a further byte gives an overflow pulse and no write.
//   - 0x08 then writes addr 31 with lane 7 = 0 and full=0.
// - Clear with data present:
//   - 31 consecutive write pulses, addr 1..31, data 0; char_ready=0 throughout.
//   - cursor ends at (1,0).
// - Assert reset during the CLEAR sweep at addr 10:
//   - write drops asynchronously; outputs return to reset values.
//   - char_ready=1 after release.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared definitions for the keyboard-to-registerfile character path:
// writer state encoding, registerfile address range and the backspace code.
package keyboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FETCH = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  localparam int         WORD_BYTES     = 8;
  localparam logic [7:0] BACKSPACE_CODE = 8'h08;
  localparam logic [4:0] FIRST_ADDR     = 5'd1;
  localparam logic [4:0] LAST_ADDR      = 5'd31;
  localparam logic [2:0] LAST_LANE      = 3'd7;

endpackage

// File: rtl/byte_lane_update.sv
// Combinational byte-lane replacement: returns word_i with lane lane_i set to
// value_i. Lane 0 is bits [7:0]. Used for inserting a character and for erasing
// one (value 0).
module byte_lane_update
  import keyboard_pkg::*;
(
  input  logic [WORD_BYTES*8-1:0] word_i,
  input  logic [2:0]              lane_i,
  input  logic [7:0]              value_i,
  output logic [WORD_BYTES*8-1:0] word_o
);

  logic [5:0] shift_s;

  assign shift_s = {lane_i, 3'b000};
  assign word_o  = (word_i & ~(64'h0000_0000_0000_00FF << shift_s))
                 | ({56'd0, value_i} << shift_s);

endmodule

// File: rtl/character_buffer_writer.sv
// Packs decoded keyboard bytes eight per 64-bit word into registerfile entries
// 1..31, rewriting the current word after every accepted byte. Handles
// backspace (refetching the previous word across a word boundary) and a bulk
// clear sweep that zeroes every writable entry.
module character_buffer_writer
  import keyboard_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        clear,
  output logic [63:0] data_out,
  output logic [4:0]  address,
  output logic        write,
  output logic [4:0]  select_b,
  input  logic [63:0] rf_out_b,
  output logic [4:0]  cursor_addr,
  output logic [2:0]  cursor_byte,
  output logic        full,
  output logic        overflow
);

  state_e      state_q;
  logic [63:0] word_q;
  logic [4:0]  cur_addr_q;
  logic [2:0]  cur_byte_q;
  logic        full_q;
  logic        overflow_q;
  logic        write_q;
  logic [63:0] data_out_q;
  logic [4:0]  address_q;
  logic [4:0]  select_b_q;
  logic        advance_q;

  logic        is_bs_s;
  logic [2:0]  lane_s;
  logic [7:0]  value_s;
  logic [63:0] lane_word_s;
  logic [63:0] fetched_s;

  assign is_bs_s   = (char_in == BACKSPACE_CODE);
  // The refetched word loses its last character, which sits in lane 7.
  assign fetched_s = {8'd0, rf_out_b[55:0]};

  // Pick the lane to modify: insert at the cursor, erase the slot before it
  // (or the cursor slot itself when the buffer is full and the cursor held).
  always_comb begin
    lane_s  = cur_byte_q;
    value_s = char_in;
    if (is_bs_s) begin
      value_s = 8'd0;
      if (full_q) begin
        lane_s = cur_byte_q;
      end else begin
        lane_s = cur_byte_q - 3'd1;
      end
    end else begin
      lane_s  = cur_byte_q;
      value_s = char_in;
    end
  end

  byte_lane_update u_lane (
    .word_i  (word_q),
    .lane_i  (lane_s),
    .value_i (value_s),
    .word_o  (lane_word_s)
  );

  // Writer FSM: all outputs registered; write pulses for exactly the cycles
  // spent in WRITE and CLEAR.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      word_q     <= 64'd0;
      cur_addr_q <= FIRST_ADDR;
      cur_byte_q <= 3'd0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      write_q    <= 1'b0;
      data_out_q <= 64'd0;
      address_q  <= FIRST_ADDR;
      select_b_q <= 5'd0;
      advance_q  <= 1'b0;
    end else begin
      write_q    <= 1'b0;
      overflow_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clear) begin
            state_q    <= ST_CLEAR;
            write_q    <= 1'b1;
            address_q  <= FIRST_ADDR;
            data_out_q <= 64'd0;
          end else if (char_valid) begin
            if (!is_bs_s) begin
              if (full_q) begin
                overflow_q <= 1'b1;
              end else begin
                word_q     <= lane_word_s;
                data_out_q <= lane_word_s;
                address_q  <= cur_addr_q;
                write_q    <= 1'b1;
                advance_q  <= 1'b1;
                state_q    <= ST_WRITE;
              end
            end else if (full_q || (cur_byte_q != 3'd0)) begin
              // Erase within the current word; a full buffer keeps its cursor.
              if (!full_q) begin
                cur_byte_q <= cur_byte_q - 3'd1;
              end
              full_q     <= 1'b0;
              word_q     <= lane_word_s;
              data_out_q <= lane_word_s;
              address_q  <= cur_addr_q;
              write_q    <= 1'b1;
              advance_q  <= 1'b0;
              state_q    <= ST_WRITE;
            end else if (cur_addr_q > FIRST_ADDR) begin
              select_b_q <= cur_addr_q - 5'd1;
              state_q    <= ST_FETCH;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (advance_q) begin
            if (cur_byte_q != LAST_LANE) begin
              cur_byte_q <= cur_byte_q + 3'd1;
            end else if (cur_addr_q != LAST_ADDR) begin
              cur_addr_q <= cur_addr_q + 5'd1;
              cur_byte_q <= 3'd0;
              word_q     <= 64'd0;
            end else begin
              full_q <= 1'b1;
            end
          end
          advance_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        ST_FETCH: begin
          word_q     <= fetched_s;
          data_out_q <= fetched_s;
          address_q  <= cur_addr_q - 5'd1;
          cur_addr_q <= cur_addr_q - 5'd1;
          cur_byte_q <= LAST_LANE;
          advance_q  <= 1'b0;
          write_q    <= 1'b1;
          state_q    <= ST_WRITE;
        end
        ST_CLEAR: begin
          if (address_q == LAST_ADDR) begin
            word_q     <= 64'd0;
            cur_addr_q <= FIRST_ADDR;
            cur_byte_q <= 3'd0;
            full_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            address_q <= address_q + 5'd1;
            write_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign char_ready  = (state_q == ST_IDLE);
  assign data_out    = data_out_q;
  assign address     = address_q;
  assign write       = write_q;
  assign select_b    = select_b_q;
  assign cursor_addr = cur_addr_q;
  assign cursor_byte = cur_byte_q;
  assign full        = full_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_character_buffer_writer.sv
// Scoreboard bench: the buffer is modelled as a plain queue of typed
// characters; each write the writer should issue is derived from that text and
// queued, and a monitor compares every observed write pulse against the queue.
module tb_character_buffer_writer;

  logic        clock;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        clear;
  logic [63:0] data_out;
  logic [4:0]  address;
  logic        write;
  logic [4:0]  select_b;
  logic [63:0] rf_out_b;
  logic [4:0]  cursor_addr;
  logic [2:0]  cursor_byte;
  logic        full;
  logic        overflow;

  character_buffer_writer dut (
    .clock       (clock),
    .reset       (reset),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .clear       (clear),
    .data_out    (data_out),
    .address     (address),
    .write       (write),
    .select_b    (select_b),
    .rf_out_b    (rf_out_b),
    .cursor_addr (cursor_addr),
    .cursor_byte (cursor_byte),
    .full        (full),
    .overflow    (overflow)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  text [$];
  logic [68:0] exp_q [$];
  logic [68:0] mon_e;
  logic [63:0] rf [32];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registerfile model: synchronous write, combinational read B, entry 0 is zero.
  always @(posedge clock) if (write) rf[address] <= data_out;
  assign rf_out_b = (select_b == 5'd0) ? 64'd0 : rf[select_b];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_word(input int idx);
    logic [63:0] w;
    w = 64'd0;
    for (int k = 0; k < 8; k++)
      if (idx * 8 + k < text.size()) w[k*8 +: 8] = text[idx*8 + k];
    return w;
  endfunction

  // Monitor: every write pulse must match the next expected write.
  always @(negedge clock) begin
    if (reset && write) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=%0d data=%h expected none", address, data_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 64'(address), 64'(mon_e[68:64]));
        check("write_data", data_out, mon_e[63:0]);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (!char_ready && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("idle_reached", 64'(char_ready), 64'd1);
  endtask

  task automatic check_cursor();
    int len;
    len = text.size();
    if (len == 248) begin
      check("cursor_addr", 64'(cursor_addr), 64'd31);
      check("cursor_byte", 64'(cursor_byte), 64'd7);
      check("full", 64'(full), 64'd1);
    end else begin
      check("cursor_addr", 64'(cursor_addr), 64'(1 + len / 8));
      check("cursor_byte", 64'(cursor_byte), 64'(len % 8));
      check("full", 64'(full), 64'd0);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int  idx;
    bit  ovf_exp;
    bit  fetch_exp;
    ovf_exp = 0;
    fetch_exp = 0;
    wait_idle();
    if (b != 8'h08) begin
      if (text.size() < 248) begin
        idx = text.size() / 8;
        text.push_back(b);
        exp_q.push_back({5'(1 + idx), pack_word(idx)});
      end else begin
        ovf_exp = 1;
      end
    end else if (text.size() > 0) begin
      fetch_exp = (text.size() % 8 == 0) && (text.size() < 248);
      idx = (text.size() - 1) / 8;
      void'(text.pop_back());
      exp_q.push_back({5'(1 + idx), pack_word(idx)});
    end
    char_in = b;
    char_valid = 1'b1;
    @(posedge clock);
    #1 char_valid = 1'b0;
    if (ovf_exp) begin
      @(negedge clock);
      check("overflow_pulse", 64'(overflow), 64'd1);
      check("overflow_no_write", 64'(write), 64'd0);
    end
    if (fetch_exp) begin
      @(negedge clock);
      check("fetch_select_b", 64'(select_b), 64'(1 + (text.size() / 8)));
      check("fetch_no_write", 64'(write), 64'd0);
    end
    wait_idle();
    check_cursor();
  endtask

  task automatic do_clear();
    wait_idle();
    for (int a = 1; a <= 31; a++) exp_q.push_back({5'(a), 64'd0});
    text.delete();
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    char_in = 8'h5A;
    char_valid = 1'b1;
    for (int c = 0; c < 31; c++) begin
      @(negedge clock);
      check("clear_ready_low", 64'(char_ready), 64'd0);
      check("clear_write_high", 64'(write), 64'd1);
      if (c == 29) char_valid = 1'b0;
    end
    wait_idle();
    check_cursor();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    reset = 1'b0;
    char_in = 8'd0;
    char_valid = 1'b0;
    clear = 1'b0;
    #23;
    check("rst_ready", 64'(char_ready), 64'd1);
    check("rst_write", 64'(write), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    check("rst_address", 64'(address), 64'd1);
    check("rst_select_b", 64'(select_b), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check_cursor();
    @(negedge clock);
    reset = 1'b1;

    // "AB" from reset, then a clear with data present.
    send(8'h41);
    send(8'h42);
    do_clear();

    // One full word, then a backspace across the word boundary.
    for (int i = 0; i < 8; i++) send(8'(8'h30 + i));
    send(8'h08);
    send(8'h61);

    // Random typing with backspaces.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 99) < 20) send(8'h08);
      else send(8'($urandom_range(32, 126)));
    end

    // Fill to capacity, overflow once, then erase the last slot.
    while (text.size() < 248) send(8'($urandom_range(32, 126)));
    send(8'h7E);
    send(8'h08);
    send(8'h08);
    send(8'h21);
    send(8'h22);

    // Backspace at the very first slot is ignored.
    do_clear();
    send(8'h08);
    send(8'h43);
    send(8'h08);
    send(8'h08);

    // Reset in the middle of a clear sweep.
    for (int i = 0; i < 20; i++) send(8'($urandom_range(32, 126)));
    wait_idle();
    for (int a = 1; a <= 31; a++) exp_q.push_back({5'(a), 64'd0});
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    n = 0;
    @(negedge clock);
    while (!(write && address == 5'd10) && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("sweep_reached_10", 64'(address), 64'd10);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    text.delete();
    check("abort_write", 64'(write), 64'd0);
    check("abort_address", 64'(address), 64'd1);
    check("abort_data_out", data_out, 64'd0);
    check("abort_ready", 64'(char_ready), 64'd1);
    check_cursor();
    @(posedge clock);
    #1 check("abort_write_held", 64'(write), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    wait_idle();
    send(8'h44);
    send(8'h45);

    repeat (3) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
